bram_arbiter: RTL

- Two-port request/acknowledge arbiter that shares the single-port 256x8 bram (one addr/data/readWrite set, registered 1-cycle read output) between two requesters.
- Serialises accesses with a round-robin or fixed-priority grant.
- Sequences each access through issue and capture cycles and returns registered read data plus a one-cycle ack per transaction.
- Sits between the bram instance and its client logic; the bram's own reset is wired by the integration, not by this block.

---
 rtl/bram_arbiter_pkg.sv | 16 +
 rtl/bram_arbiter_if.sv | 45 ++++
 rtl/bram_arbiter_rr_arb2.sv | 24 ++
 rtl/bram_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared types and constants for the two-port BRAM arbiter.
package bram_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/bram_arbiter_if.sv
// Client request/ack ports and BRAM-facing bus bundled for the arbiter.
interface bram_arbiter_if
  import bram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Clients plus the BRAM itself sit on the master side.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_rw, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, rdata0, ack1, rdata1,
    output mem_rw, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/bram_arbiter_rr_arb2.sv
// Combinational two-way picker: round-robin on last_grant or fixed port-0 priority.
module rr_arb2
  import bram_arbiter_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_idx_o
);

  always_comb begin
    grant_valid_o = req0_i | req1_i;
    grant_idx_o   = PORT0;
    if (req0_i && req1_i) begin
      grant_idx_o = FAIR ? ~last_grant_i : PORT0;
    end else if (req1_i) begin
      grant_idx_o = PORT1;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port BRAM between two requesters; IDLE -> ISSUE -> RESP per access.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit FAIR   = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  bram_arbiter_if.slave  bus,
  output logic           busy,
  output logic           last_grant
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              g_we_q, g_we_d;
  logic [ADDR_W-1:0] g_addr_q, g_addr_d;
  logic [DATA_W-1:0] g_wdata_q, g_wdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              grant_valid;
  logic              grant_idx;

  rr_arb2 #(
    .FAIR (FAIR)
  ) u_pick (
    .req0_i        (bus.req0),
    .req1_i        (bus.req1),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT1;
      g_we_q       <= 1'b0;
      g_addr_q     <= '0;
      g_wdata_q    <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      g_we_q       <= g_we_d;
      g_addr_q     <= g_addr_d;
      g_wdata_q    <= g_wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    g_we_d       = g_we_q;
    g_addr_d     = g_addr_q;
    g_wdata_d    = g_wdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant_idx;
          state_d      = ISSUE;
          if (grant_idx == PORT1) begin
            g_we_d    = bus.we1;
            g_addr_d  = bus.addr1;
            g_wdata_d = bus.wdata1;
          end else begin
            g_we_d    = bus.we0;
            g_addr_d  = bus.addr0;
            g_wdata_d = bus.wdata0;
          end
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        // last_grant_q still names the port that owns this transaction.
        state_d = IDLE;
        if (last_grant_q == PORT1) begin
          ack1_d = 1'b1;
          if (!g_we_q) rdata1_d = bus.mem_rdata;
        end else begin
          ack0_d = 1'b1;
          if (!g_we_q) rdata0_d = bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write strobe only in ISSUE and gated by reset so an aborted write never lands.
  assign bus.mem_rw    = (state_q == ISSUE) && g_we_q && reset;
  assign bus.mem_addr  = g_addr_q;
  assign bus.mem_wdata = g_wdata_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign busy          = (state_q != IDLE);
  assign last_grant    = last_grant_q;

endmodule
